lift_call_scheduler: RTL and testbench

LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

---
 rtl/lift_call_scheduler.sv | 170 +++++++++++++++++
 tb/tb_lift_call_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler for a 4-floor lift: latches hall calls, issues one target at a time, dwells after arrival.
// Build option: define CALL_DEBOUNCE_EN for synchronized, 3-sample-debounced call capture.
module lift_call_scheduler #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [3:0] cur_floor,
  input  logic       stop,
  input  logic       door,
  output logic [3:0] req_floor,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DWELL} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_req, w_req_next;
  logic [3:0] r_pending, w_pending_next;
  logic       r_dir, w_dir_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [3:0] w_rise;
  logic [3:0] w_clr;
  logic       w_onehot;

`ifdef CALL_DEBOUNCE_EN
  logic [3:0] r_sync1, r_sync2, r_hist0, r_hist1, r_press_prev;
  logic [3:0] w_pressed;

  // A call counts once the synchronized level has been high for three samples.
  assign w_pressed = r_sync2 & r_hist0 & r_hist1;
  assign w_rise    = w_pressed & ~r_press_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= call_btn;
      r_sync2      <= call_btn;
      r_hist0      <= call_btn;
      r_hist1      <= call_btn;
      r_press_prev <= call_btn;
    end else begin
      r_sync1      <= call_btn;
      r_sync2      <= r_sync1;
      r_hist0      <= r_sync2;
      r_hist1      <= r_hist0;
      r_press_prev <= w_pressed;
    end
  end
`else
  logic [3:0] r_btn_prev;

  assign w_rise = call_btn & ~r_btn_prev;

  always_ff @(posedge clk) begin
    r_btn_prev <= call_btn;
  end
`endif

  assign w_onehot = (cur_floor != 4'b0000) && ((cur_floor & (cur_floor - 4'd1)) == 4'b0000);

  // SCAN target selection from the current position and sweep direction.
  logic [1:0] w_cur_idx;
  logic [1:0] w_up_idx, w_dn_idx;
  logic       w_up_found, w_dn_found;
  logic [3:0] w_sel;
  logic       w_sel_dir;

  always_comb begin
    w_cur_idx  = 2'd0;
    w_up_idx   = 2'd0;
    w_dn_idx   = 2'd0;
    w_up_found = 1'b0;
    w_dn_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur_floor[i]) w_cur_idx = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(w_cur_idx))) begin
        w_up_idx   = 2'(i);
        w_up_found = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r_pending[i] && (i < int'(w_cur_idx))) begin
        w_dn_idx   = 2'(i);
        w_dn_found = 1'b1;
      end
    end
    w_sel     = 4'b0000;
    w_sel_dir = r_dir;
    if ((r_pending & cur_floor) != 4'b0000) begin
      w_sel = cur_floor;
    end else if (r_dir) begin
      if (w_up_found) begin
        w_sel = 4'b0001 << w_up_idx;
      end else begin
        w_sel     = 4'b0001 << w_dn_idx;
        w_sel_dir = 1'b0;
      end
    end else begin
      if (w_dn_found) begin
        w_sel = 4'b0001 << w_dn_idx;
      end else begin
        w_sel     = 4'b0001 << w_up_idx;
        w_sel_dir = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_dir_next   = r_dir;
    w_cnt_next   = r_cnt;
    w_clr        = 4'b0000;
    // A bad floor code freezes the sequencer; call capture keeps running.
    if (w_onehot) begin
      case (r_state)
        S_IDLE: begin
          if (r_pending != 4'b0000) begin
            w_req_next   = w_sel;
            w_dir_next   = w_sel_dir;
            w_state_next = S_SERVE;
          end
        end
        S_SERVE: begin
          if ((cur_floor == r_req) && stop && door) begin
            w_clr        = r_req;
            w_req_next   = 4'b0000;
            w_cnt_next   = 8'(DWELL_CYCLES - 1);
            w_state_next = S_DWELL;
          end
        end
        S_DWELL: begin
          if (r_cnt == 8'd0) w_state_next = S_IDLE;
          else               w_cnt_next   = r_cnt - 8'd1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
    w_pending_next = (r_pending | w_rise) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= 4'b0000;
      r_pending <= 4'b0000;
      r_dir     <= 1'b1;
      r_cnt     <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_req     <= w_req_next;
      r_pending <= w_pending_next;
      r_dir     <= w_dir_next;
      r_cnt     <= w_cnt_next;
    end
  end

  assign req_floor = w_onehot ? r_req : 4'b0000;
  assign pending   = r_pending;
  assign dir_up    = r_dir;
  assign busy      = (r_state != S_IDLE);
  assign fault     = ~w_onehot;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed scoreboard bench for lift_call_scheduler (default capture build, DWELL_CYCLES = 4).
module tb_lift_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_btn;
  logic [3:0] cur_floor;
  logic       stop;
  logic       door;
  logic [3:0] req_floor;
  logic [3:0] pending;
  logic       dir_up;
  logic       busy;
  logic       fault;

  lift_call_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .call_btn (call_btn),
    .cur_floor(cur_floor),
    .stop     (stop),
    .door     (door),
    .req_floor(req_floor),
    .pending  (pending),
    .dir_up   (dir_up),
    .busy     (busy),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [3:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%b expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    end
    $display("[%0t] %s observed=%b expected=%b", $time, e.tag, obs, e.val);
  endtask

  task automatic expect_reset_vals();
    expect_v("rst_req", 4'b0000);
    expect_v("rst_pend", 4'b0000);
    expect_v("rst_dir", 4'd1);
    expect_v("rst_busy", 4'd0);
    expect_v("rst_fault", 4'd0);
  endtask

  task automatic check_reset_vals();
    check(req_floor);
    check(pending);
    check({3'b000, dir_up});
    check({3'b000, busy});
    check({3'b000, fault});
  endtask

  initial begin
    reset = 1'b1; call_btn = 4'b0000; cur_floor = 4'b0001; stop = 1'b1; door = 1'b1;
    tick(); tick();
    expect_reset_vals();
    check_reset_vals();
    reset = 1'b0;

    // Basic call from floor 0 to floor 2.
    call_btn = 4'b0100;
    expect_v("call_pend", 4'b0100); expect_v("call_busy0", 4'd0);
    tick();
    check(pending); check({3'b000, busy});
    call_btn = 4'b0000;
    expect_v("serve_req", 4'b0100); expect_v("serve_busy", 4'd1); expect_v("serve_dir", 4'd1);
    tick();
    check(req_floor); check({3'b000, busy}); check({3'b000, dir_up});

    // Arrival at floor 2 and dwell timing.
    cur_floor = 4'b0100;
    expect_v("arr_pend", 4'b0000); expect_v("arr_req", 4'b0000); expect_v("arr_busy", 4'd1);
    tick();
    check(pending); check(req_floor); check({3'b000, busy});
    tick(); tick();
    expect_v("dwell_last_busy", 4'd1);
    tick();
    check({3'b000, busy});
    expect_v("dwell_end_busy", 4'd0);
    tick();
    check({3'b000, busy});

    // Sweep order: at floor 1 heading up, calls on 0 and 3.
    cur_floor = 4'b0010; call_btn = 4'b1001;
    expect_v("sweep_pend", 4'b1001);
    tick();
    check(pending);
    call_btn = 4'b0000;
    expect_v("sweep_req1", 4'b1000); expect_v("sweep_dir1", 4'd1);
    tick();
    check(req_floor); check({3'b000, dir_up});
    cur_floor = 4'b1000;
    expect_v("sweep_arr_pend", 4'b0001); expect_v("sweep_arr_req", 4'b0000);
    tick();
    check(pending); check(req_floor);
    tick(); tick(); tick();
    expect_v("sweep_idle_busy", 4'd0);
    tick();
    check({3'b000, busy});
    expect_v("sweep_req2", 4'b0001); expect_v("sweep_dir2", 4'd0);
    tick();
    check(req_floor); check({3'b000, dir_up});

    // Clear wins on the arriving floor; another floor's edge still latches.
    cur_floor = 4'b0001; call_btn = 4'b0101;
    expect_v("clrwin_pend", 4'b0100); expect_v("clrwin_req", 4'b0000);
    tick();
    check(pending); check(req_floor);
    tick(); tick(); tick();
    expect_v("held_pend", 4'b0100); expect_v("held_busy", 4'd0);
    tick();
    check(pending); check({3'b000, busy});
    expect_v("reverse_req", 4'b0100); expect_v("reverse_dir", 4'd1);
    tick();
    check(req_floor); check({3'b000, dir_up});

    // Fault: illegal floor codes freeze the target and force req_floor low.
    stop = 1'b0;
    cur_floor = 4'b0110;
    #1;
    expect_v("fault_on", 4'd1); expect_v("fault_req", 4'b0000);
    check({3'b000, fault}); check(req_floor);
    call_btn = 4'b1111;
    expect_v("fault_pend", 4'b1110); expect_v("fault_busy", 4'd1); expect_v("fault_req2", 4'b0000);
    tick();
    check(pending); check({3'b000, busy}); check(req_floor);
    cur_floor = 4'b0000;
    #1;
    expect_v("fault_zero", 4'd1); expect_v("fault_zero_req", 4'b0000);
    check({3'b000, fault}); check(req_floor);
    tick();
    cur_floor = 4'b0100;
    #1;
    expect_v("fault_clear", 4'd0); expect_v("resume_req", 4'b0100); expect_v("resume_busy", 4'd1);
    check({3'b000, fault}); check(req_floor); check({3'b000, busy});
    expect_v("wait_req", 4'b0100); expect_v("wait_pend", 4'b1110);
    tick();
    check(req_floor); check(pending);

    // Reset mid-SERVE abandons everything; held buttons do not re-trigger.
    reset = 1'b1;
    expect_reset_vals();
    tick();
    check_reset_vals();
    reset = 1'b0;
    expect_v("post_rst_pend", 4'b0000); expect_v("post_rst_busy", 4'd0);
    tick();
    check(pending); check({3'b000, busy});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
